// File: rtl/debug_access_master.sv
// debug_access_master: initiator for the 8-bit-address / 32-bit-data debug register bus.
// Accepts commands on a valid/ready channel and drives the debug bus. Supports a single
// write or an incrementing-address read burst of cmd_len+1 beats. Every access returns
// exactly one beat on the valid/ready response channel. All outputs are registered.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   cmd_valid/ready  command handshake; cmd_ready is high only in idle
//   cmd_write        1 = write, 0 = read
//   cmd_addr         start address
//   cmd_len          read beats minus one (ignored for writes)
//   cmd_wdata        write data
//   rsp_valid/ready  response handshake, one beat per access
//   rsp_data         read data, 0 for write acks
//   rsp_last         final beat of the command
//   busy             high whenever not idle
//   debug_addr/enable/write/data_in  bus request, enable is a one-cycle strobe
//   debug_data_out   bus read data, valid READ_LATENCY cycles after the strobe edge
module debug_access_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_LEN_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [7:0]           cmd_addr,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_last,
  output logic                 busy,
  output logic [7:0]           debug_addr,
  output logic                 debug_enable,
  output logic                 debug_write,
  output logic [31:0]          debug_data_in,
  input  logic [31:0]          debug_data_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cur_addr_q, cur_addr_d;
  logic [MAX_LEN_W-1:0] remain_q, remain_d;
  logic                 write_q, write_d;
  logic [2:0]           wait_cnt_q, wait_cnt_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 busy_q, busy_d;
  logic [7:0]           debug_addr_q, debug_addr_d;
  logic                 debug_enable_q, debug_enable_d;
  logic                 debug_write_q, debug_write_d;
  logic [31:0]          debug_data_in_q, debug_data_in_d;

  logic                 cmd_accept;

  // cmd_ready_q is itself the advertised ready, so the first post-reset cycle
  // (ready still 0) cannot consume a command.
  assign cmd_accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remain_d        = remain_q;
    write_d         = write_q;
    wait_cnt_d      = wait_cnt_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_last_d      = rsp_last_q;
    debug_enable_d  = 1'b0;
    debug_write_d   = 1'b0;
    debug_addr_d    = debug_addr_q;
    debug_data_in_d = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          cur_addr_d      = cmd_addr;
          remain_d        = cmd_write ? '0 : cmd_len;
          write_d         = cmd_write;
          state_d         = StIssue;
          debug_enable_d  = 1'b1;
          debug_addr_d    = cmd_addr;
          debug_write_d   = cmd_write;
          debug_data_in_d = cmd_write ? cmd_wdata : 32'h0;
        end
      end
      StIssue: begin
        if (write_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'h0;
          rsp_last_d  = 1'b1;
        end else begin
          state_d    = StWait;
          wait_cnt_d = 3'(READ_LATENCY - 1);
        end
      end
      StWait: begin
        if (wait_cnt_q == 3'd0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = debug_data_out;
          rsp_last_d  = (remain_q == '0);
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (remain_q != '0) begin
            cur_addr_d     = cur_addr_q + 8'd1;
            remain_d       = remain_q - MAX_LEN_W'(1);
            state_d        = StIssue;
            debug_enable_d = 1'b1;
            debug_addr_d   = cur_addr_q + 8'd1;
            debug_write_d  = write_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cur_addr_q      <= '0;
      remain_q        <= '0;
      write_q         <= 1'b0;
      wait_cnt_q      <= '0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      debug_addr_q    <= '0;
      debug_enable_q  <= 1'b0;
      debug_write_q   <= 1'b0;
      debug_data_in_q <= '0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remain_q        <= remain_d;
      write_q         <= write_d;
      wait_cnt_q      <= wait_cnt_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_last_q      <= rsp_last_d;
      busy_q          <= busy_d;
      debug_addr_q    <= debug_addr_d;
      debug_enable_q  <= debug_enable_d;
      debug_write_q   <= debug_write_d;
      debug_data_in_q <= debug_data_in_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_last      = rsp_last_q;
  assign busy          = busy_q;
  assign debug_addr    = debug_addr_q;
  assign debug_enable  = debug_enable_q;
  assign debug_write   = debug_write_q;
  assign debug_data_in = debug_data_in_q;

endmodule

// File: tb/tb_debug_access_master.sv
// Testbench for debug_access_master: a responder model with configurable read latency,
// directed scenarios (write, read, burst, wrap, backpressure, mid-burst reset) and a
// randomized command stream checked against a reference memory.
module tb_debug_access_master;

  localparam int unsigned RL   = 3;
  localparam int unsigned LENW = 4;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [7:0]      cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [31:0]     cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_last;
  logic            busy;
  logic [7:0]      debug_addr;
  logic            debug_enable;
  logic            debug_write;
  logic [31:0]     debug_data_in;
  logic [31:0]     debug_data_out;

  debug_access_master #(
    .READ_LATENCY(RL),
    .MAX_LEN_W   (LENW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .busy          (busy),
    .debug_addr    (debug_addr),
    .debug_enable  (debug_enable),
    .debug_write   (debug_write),
    .debug_data_in (debug_data_in),
    .debug_data_out(debug_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt_word(input logic [7:0] a);
    return {8'hC3, a, ~a, 8'h5A};
  endfunction

  // Responder: writes land in resp_mem; reads return after RL cycles, then hold.
  logic [31:0] resp_mem     [256];
  bit          resp_written [256];
  logic [31:0] pend_val;
  int          pend_cnt = 0;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return resp_written[a] ? resp_mem[a] : dflt_word(a);
  endfunction

  always @(posedge clk) begin
    if (debug_enable && debug_write) begin
      resp_mem[debug_addr]     <= debug_data_in;
      resp_written[debug_addr] <= 1'b1;
    end
    if (debug_enable && !debug_write) begin
      if (RL == 1) debug_data_out <= rd_word(debug_addr);
      else begin
        pend_val <= rd_word(debug_addr);
        pend_cnt <= RL - 1;
      end
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1) debug_data_out <= pend_val;
    end
  end

  int strobe_cnt = 0;
  always @(negedge clk) if (debug_enable) strobe_cnt++;

  // Reference memory: what the register space should contain from the bench's view.
  logic [31:0] ref_mem [256];

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [LENW-1:0] l,
                          input logic [31:0] d);
    bit accepted = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_wdata = d;
    for (int k = 0; k < 50; k++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic wait_strobe(output int k, output bit found);
    found = 0;
    k = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (debug_enable) begin
        found = 1;
        k = j;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int k, output bit found);
    found = 0;
    k = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1;
        k = j + 1;
        break;
      end
    end
  endtask

  // Run one command to completion. stall_beat < 0 means no backpressure.
  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [LENW-1:0] l,
                         input logic [31:0] d, input int stall_beat, input int stall_cyc);
    int          nbeats = w ? 1 : int'(l) + 1;
    int          s0     = strobe_cnt;
    int          k;
    bit          found;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic [31:0] held;
    send_cmd(w, a, l, d);
    for (int i = 0; i < nbeats; i++) begin
      ea = a + 8'(i);
      ed = w ? 32'h0 : ref_mem[ea];
      wait_strobe(k, found);
      check_eq("strobe_seen", 32'(found), 32'd1);
      if (!found) return;
      check_eq("strobe_delay", 32'(k), 32'd0);
      check_eq("strobe_addr", 32'(debug_addr), 32'(ea));
      check_eq("strobe_write", 32'(debug_write), 32'(w));
      check_eq("strobe_wdata", debug_data_in, w ? d : 32'h0);
      if (i == stall_beat) rsp_ready = 1'b0;
      wait_rsp(k, found);
      check_eq("rsp_seen", 32'(found), 32'd1);
      if (!found) begin
        rsp_ready = 1'b1;
        return;
      end
      check_eq("rsp_latency", 32'(k), w ? 32'd1 : 32'(RL + 1));
      check_eq("rsp_data", rsp_data, ed);
      check_eq("rsp_last", 32'(rsp_last), 32'(i == nbeats - 1));
      check_eq("busy_in_cmd", 32'(busy), 32'd1);
      if (i == stall_beat) begin
        held = rsp_data;
        // A competing command during the stall must be ignored.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < stall_cyc; c++) begin
          @(negedge clk);
          check_eq("stall_valid", 32'(rsp_valid), 32'd1);
          check_eq("stall_data", rsp_data, held);
          check_eq("stall_last", 32'(rsp_last), 32'(i == nbeats - 1));
          check_eq("stall_strobe", 32'(debug_enable), 32'd0);
          check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      if (w) ref_mem[a] = d;
    end
    @(negedge clk);
    check_eq("end_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("end_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("end_strobe_count", 32'(strobe_cnt - s0), 32'(nbeats));
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    bit  found;
    int  s0;
    logic            w;
    logic [7:0]      a;
    logic [LENW-1:0] l;
    int              sb;

    for (int i = 0; i < 256; i++) ref_mem[i] = dflt_word(8'(i));
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_rsp_last", 32'(rsp_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_enable", 32'(debug_enable), 32'd0);
    check_eq("rst_write", 32'(debug_write), 32'd0);
    check_eq("rst_addr", 32'(debug_addr), 32'd0);
    check_eq("rst_wdata", debug_data_in, 32'h0);
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    run_cmd(1'b1, 8'h03, 4'd5, 32'hA5A5_0001, -1, 0);
    run_cmd(1'b0, 8'h03, 4'd0, 32'h0, -1, 0);
    for (int i = 0; i < 8; i++) run_cmd(1'b1, 8'(i), 4'd0, 32'(i + 1), -1, 0);
    run_cmd(1'b0, 8'h00, 4'd7, 32'h0, -1, 0);
    run_cmd(1'b0, 8'hFE, 4'd2, 32'h0, -1, 0);
    run_cmd(1'b0, 8'h10, 4'd3, 32'h0, 1, 10);

    // Reset while the second beat of a burst is waiting for read data.
    send_cmd(1'b0, 8'h20, 4'd3, 32'h0);
    wait_strobe(k, found);
    wait_rsp(k, found);
    wait_strobe(k, found);
    check_eq("mid_rst_second_strobe", 32'(found), 32'd1);
    check_eq("mid_rst_second_addr", 32'(debug_addr), 32'h21);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_enable", 32'(debug_enable), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    s0 = strobe_cnt;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("mid_rst_quiet_rsp", 32'(rsp_valid), 32'd0);
    end
    check_eq("mid_rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    run_cmd(1'b0, 8'h20, 4'd1, 32'h0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      w  = ($urandom_range(0, 3) == 0);
      a  = 8'($urandom_range(0, 255));
      l  = LENW'($urandom_range(0, 15));
      sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w ? 0 : int'(l))) : -1;
      run_cmd(w, a, l, $urandom, sb, int'($urandom_range(1, 6)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
